filt_level_detect: RTL and testbench
====================================

# filt_level_detect

Downstream consumer of the first-order IIR smoothing stage's 8-bit output. It applies a debounced hysteresis comparator to the filtered sample stream. It produces a registered level flag with single-cycle rise/fall event pulses, plus an optional windowed peak-hold value. It sits between the smoothing filter and the control/status logic that acts on signal level.

## Interface
Parameters:
- `DW`, 8: sample width; matches the filter output.
- `TH_HI`, 8'd160: rise threshold; sample >= TH_HI qualifies as high.
- `TH_LO`, 8'd96: fall threshold; sample <= TH_LO qualifies as low. Must satisfy TH_LO < TH_HI.
- `DEB_N`, 4: consecutive qualifying valid samples needed to change level. Range 1..15.
- `WIN_LEN`, 256: peak window length in valid samples. Range 2..65535.

Ports:
- `clk`, input, 1: clock; all logic on the rising edge.
- `rst`, input, 1: reset; synchronous, active-high.
- `i_vld`, input, 1: sample valid. Tie to 1 when the upstream filter updates every cycle.
- `i_data`, input, DW: filtered sample; unsigned.
- `o_level`, output, 1: debounced level; 1 = high.
- `o_rise`, output, 1: one-cycle pulse on a 0->1 change of `o_level`.
- `o_fall`, output, 1: one-cycle pulse on a 1->0 change of `o_level`.
- `o_peak`, output, DW: maximum sample of the last completed window.
- `o_peak_vld`, output, 1: one-cycle pulse when `o_peak` updates.

## Operation
- FSM states: LOW, RISE_CHK, HIGH, FALL_CHK. Debounce counter is 4 bits.
- State and counter advance only on cycles with `i_vld`=1. Cycles with `i_vld`=0 hold all state and counts.
- LOW, sample >= TH_HI:
  - If DEB_N==1: go to HIGH.
  - Otherwise: go to RISE_CHK with cnt=1.
- LOW, any other sample: stay in LOW.
- RISE_CHK, sample >= TH_HI: cnt+1. When cnt+1 == DEB_N, go to HIGH and clear cnt.
- RISE_CHK, sample < TH_HI: go to LOW and clear cnt. A single dip restarts the debounce.
- HIGH and FALL_CHK: mirror of LOW and RISE_CHK, with qualifying sample <= TH_LO and return to HIGH on sample > TH_LO.
- Samples strictly between TH_LO and TH_HI never change `o_level`. This is the hysteresis band.
- `o_level` = 1 in HIGH and FALL_CHK; 0 in LOW and RISE_CHK.
- `o_rise` asserts exactly on the RISE_CHK->HIGH or LOW->HIGH transition. `o_fall` asserts exactly on the FALL_CHK->LOW or HIGH->LOW transition.
- Peak path:
  - Running max `pk_run`; window counter `win_cnt`, 16 bits.
  - On each valid sample: `pk_run` <= max(pk_run, i_data) and `win_cnt`+1.
  - On the WIN_LEN-th valid sample:
    - `o_peak` <= max(pk_run, i_data), and `o_peak_vld` pulses.
    - `pk_run` <= 0 and `win_cnt` <= 0. The next window starts empty; no overlap, no sample dropped.

## Timing
- All outputs are registered.
- `o_level`, `o_rise`, `o_fall` update on the clock edge that samples the completing valid input: latency 1 cycle from that input.
- With `i_vld` held 1 and DEB_N=4, `o_rise` occurs 4 cycles after the first qualifying sample is presented.
- `o_rise`/`o_fall` are high for exactly one cycle, even if `i_vld` stays high. Pulses deassert on the next edge regardless of `i_vld`.
- `o_peak_vld` has 1-cycle latency from the WIN_LEN-th valid sample. `o_peak` holds until the next window completes.
- Reset values:
  - State LOW, cnt 0.
  - `o_level`, `o_rise`, `o_fall`, `o_peak_vld` = 0.
  - `o_peak` = 0, `pk_run` = 0, `win_cnt` = 0.
- Reset mid-debounce or mid-window discards the partial count. No event is emitted.
- `rst` has priority over `i_vld` in the same cycle.
- A sample exactly equal to TH_HI qualifies as high; a sample exactly equal to TH_LO qualifies as low.

## Configuration
- Macro `FILT_LEVEL_PEAK_EN`.
- Defined: the peak path is built as specified above.
- Undefined: `pk_run` and `win_cnt` are not instantiated, `o_peak` ties to 0, and `o_peak_vld` ties to 0. Port list is unchanged. The level/FSM behaviour is identical in both builds.

## Test plan
- Reset, then `i_vld`=1 with `i_data`=200 for 4 cycles: `o_rise` pulses once on cycle 4's edge, `o_level`=1 afterwards, `o_fall` stays 0.
- From HIGH, apply 50,50,120,50,50,50,50: the in-band 120 restarts the count. `o_fall` pulses only after the 4th consecutive 50, and `o_level`=0.
- From LOW, hold 159 or 130 for 20 cycles: no event. Then 160 x4: rise occurs, confirming threshold equality qualifies.
- Interleave `i_vld`=0 cycles between four 200-valued valid samples: rise occurs on the 4th valid sample; invalid cycles change nothing.
- Peak window with WIN_LEN=4 and macro defined: apply 10,90,30,20 then 5,6,7,8. First `o_peak_vld` gives `o_peak`=90, second gives 8. With the macro undefined, `o_peak` and `o_peak_vld` stay 0.
- Assert `rst` after the 3rd qualifying high sample: no `o_rise`; after release, a full 4 samples are again required.

Source files
------------

// File: rtl/filt_level_detect.sv
// -----------------------------------------------------------------------------
// filt_level_detect
//
// Turns the smoothed sample stream from the IIR stage into a debounced
// hysteresis level with one-cycle rise/fall events, and optionally reports
// the peak sample of each fixed-length window.
//
// Input handshake: valid-only stream. A sample on i_data is consumed on
// every rising clk edge where i_vld=1. There is no ready/backpressure, so
// the block always accepts. Cycles with i_vld=0 leave every state register
// and counter unchanged. Event pulses still clear on those cycles.
//
// Optional feature macro: FILT_LEVEL_PEAK_EN
//   defined   -> the windowed peak-hold path (pk_run / win_cnt) is built
//   undefined -> o_peak and o_peak_vld are tied to 0; the port list is unchanged
//
// Ports:
//   clk        : clock; all logic runs on the rising edge
//   rst        : synchronous active-high reset; takes priority over i_vld
//   i_vld      : sample valid
//   i_data     : filtered sample, unsigned, DW bits
//   o_level    : debounced level (1 = high), registered
//   o_rise     : one-cycle pulse on a 0->1 change of o_level
//   o_fall     : one-cycle pulse on a 1->0 change of o_level
//   o_peak     : maximum sample of the last completed window
//   o_peak_vld : one-cycle pulse when o_peak updates
//   dbg_state  : current FSM state (LOW=0, RISE_CHK=1, HIGH=2, FALL_CHK=3)
// -----------------------------------------------------------------------------
module filt_level_detect #(
  parameter int              DW      = 8,
  parameter logic [DW-1:0]   TH_HI   = 8'd160,
  parameter logic [DW-1:0]   TH_LO   = 8'd96,
  parameter int              DEB_N   = 4,
  parameter int              WIN_LEN = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [DW-1:0] i_data,
  output logic          o_level,
  output logic          o_rise,
  output logic          o_fall,
  output logic [DW-1:0] o_peak,
  output logic          o_peak_vld,
  output logic [1:0]    dbg_state
);

  // Elaboration-time parameter sanity check.
  if (!(TH_LO < TH_HI) || DEB_N < 1 || DEB_N > 15 ||
      WIN_LEN < 2 || WIN_LEN > 65535) begin : g_param_err
    $error("filt_level_detect: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } state_t;

  localparam logic [3:0] DEB_C = DEB_N[3:0];

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  logic       rise_d, fall_d;
  logic       q_hi, q_lo;

  // Threshold equality qualifies on both sides.
  assign q_hi    = (i_data >= TH_HI);
  assign q_lo    = (i_data <= TH_LO);
  assign cnt_inc = cnt_q + 4'd1;

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Level FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOW;
      cnt_q   <= 4'd0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Level is taken from the next state so it changes on the same edge
      // that consumes the completing sample, together with the event pulse.
      o_level <= (state_d == S_HIGH) || (state_d == S_FALL_CHK);
      o_rise  <= rise_d;
      o_fall  <= fall_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Level FSM: next-state and event logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (i_vld) begin
      unique case (state_q)
        S_LOW: begin
          if (q_hi) begin
            if (DEB_C == 4'd1) begin
              state_d = S_HIGH;
              rise_d  = 1'b1;
            end else begin
              state_d = S_RISE_CHK;
              cnt_d   = 4'd1;
            end
          end
        end
        S_RISE_CHK: begin
          if (q_hi) begin
            if (cnt_inc == DEB_C) begin
              state_d = S_HIGH;
              cnt_d   = 4'd0;
              rise_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // Any non-qualifying sample (including in-band) restarts debounce.
            state_d = S_LOW;
            cnt_d   = 4'd0;
          end
        end
        S_HIGH: begin
          if (q_lo) begin
            if (DEB_C == 4'd1) begin
              state_d = S_LOW;
              fall_d  = 1'b1;
            end else begin
              state_d = S_FALL_CHK;
              cnt_d   = 4'd1;
            end
          end
        end
        S_FALL_CHK: begin
          if (q_lo) begin
            if (cnt_inc == DEB_C) begin
              state_d = S_LOW;
              cnt_d   = 4'd0;
              fall_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = S_HIGH;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = S_LOW;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Windowed peak hold
  // ---------------------------------------------------------------------------
`ifdef FILT_LEVEL_PEAK_EN
  localparam logic [15:0] WIN_LAST = 16'(WIN_LEN - 1);

  logic [DW-1:0] pk_run;
  logic [15:0]   win_cnt;
  logic [DW-1:0] pk_max;

  // Max including the sample being consumed, so the closing sample of a
  // window is counted in that window and not carried into the next one.
  assign pk_max = (i_data > pk_run) ? i_data : pk_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      pk_run     <= '0;
      win_cnt    <= 16'd0;
      o_peak     <= '0;
      o_peak_vld <= 1'b0;
    end else begin
      o_peak_vld <= 1'b0;
      if (i_vld) begin
        if (win_cnt == WIN_LAST) begin
          o_peak     <= pk_max;
          o_peak_vld <= 1'b1;
          pk_run     <= '0;
          win_cnt    <= 16'd0;
        end else begin
          pk_run  <= pk_max;
          win_cnt <= win_cnt + 16'd1;
        end
      end
    end
  end
`else
  assign o_peak     = '0;
  assign o_peak_vld = 1'b0;
`endif

endmodule

// File: tb/tb_filt_level_detect.sv
// -----------------------------------------------------------------------------
// tb_filt_level_detect
//
// Self-checking bench for filt_level_detect (DEB_N=4, WIN_LEN=4). A
// behavioural model computes the expected outputs for every driven cycle and
// pushes them to exp_q; after each clock edge the oldest entry is popped and
// compared with the DUT outputs. The peak expectations follow the
// FILT_LEVEL_PEAK_EN macro, so the bench suits either build.
// -----------------------------------------------------------------------------
module tb_filt_level_detect;

  localparam int         DW      = 8;
  localparam logic [7:0] TH_HI   = 8'd160;
  localparam logic [7:0] TH_LO   = 8'd96;
  localparam int         DEB_N   = 4;
  localparam int         WIN_LEN = 4;
  localparam int         EW      = 12;  // {level, rise, fall, peak_vld, peak[7:0]}

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_vld = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_level, o_rise, o_fall, o_peak_vld;
  logic [DW-1:0] o_peak;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  filt_level_detect #(
    .DW(DW), .TH_HI(TH_HI), .TH_LO(TH_LO), .DEB_N(DEB_N), .WIN_LEN(WIN_LEN)
  ) dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_data(i_data),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall),
    .o_peak(o_peak), .o_peak_vld(o_peak_vld), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_rise_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model state
  logic       m_lvl = 1'b0;
  int         m_run = 0;
  logic [7:0] m_pk = '0;
  int         m_wc = 0;
  logic [7:0] m_peak = '0;

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // Advance the model by one clock and return the outputs expected after it.
  function automatic logic [EW-1:0] model_step(input logic r, input logic v, input logic [7:0] d);
    logic rise, fall, pvld;
    rise = 1'b0; fall = 1'b0; pvld = 1'b0;
    if (r) begin
      m_lvl = 1'b0; m_run = 0; m_pk = '0; m_wc = 0; m_peak = '0;
    end else if (v) begin
      if (!m_lvl) begin
        m_run = (d >= TH_HI) ? m_run + 1 : 0;
        if (m_run == DEB_N) begin m_lvl = 1'b1; m_run = 0; rise = 1'b1; end
      end else begin
        m_run = (d <= TH_LO) ? m_run + 1 : 0;
        if (m_run == DEB_N) begin m_lvl = 1'b0; m_run = 0; fall = 1'b1; end
      end
      m_wc++;
      if (m_wc == WIN_LEN) begin
        m_peak = max8(m_pk, d); pvld = 1'b1; m_pk = '0; m_wc = 0;
      end else begin
        m_pk = max8(m_pk, d);
      end
    end
`ifdef FILT_LEVEL_PEAK_EN
    return {m_lvl, rise, fall, pvld, m_peak};
`else
    return {m_lvl, rise, fall, 1'b0, 8'd0};
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    logic [EW-1:0] e;
    rst = r; i_vld = v; i_data = d;
    exp_q.push_back(model_step(r, v, d));
    @(posedge clk);
    #1;
    if (o_rise) n_rise_seen++;
    e = exp_q.pop_front();
    check("level",    32'(o_level),    32'(e[11]));
    check("rise",     32'(o_rise),     32'(e[10]));
    check("fall",     32'(o_fall),     32'(e[9]));
    check("peak_vld", 32'(o_peak_vld), 32'(e[8]));
    check("peak",     32'(o_peak),     32'(e[7:0]));
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b0, 1'b1, d);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b1, 8'(200));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [7:0] fall_pat[7] = '{8'd50, 8'd50, 8'd120, 8'd50, 8'd50, 8'd50, 8'd50};
  logic [7:0] pk_pat[8]   = '{8'd10, 8'd90, 8'd30, 8'd20, 8'd5, 8'd6, 8'd7, 8'd8};

  initial begin
    // Reset state
    do_reset(3);
    check("reset_state", 32'(dbg_state), 32'd0);

    // Rise after four 200s, then further highs give no second event
    n_rise_seen = 0;
    for (int i = 0; i < 6; i++) send(8'd200);
    check("single_rise", 32'(n_rise_seen), 32'd1);

    // In-band dip restarts fall debounce
    for (int i = 0; i < 7; i++) send(fall_pat[i]);

    // Hysteresis band and just-below threshold: no events, then equality rises
    for (int i = 0; i < 10; i++) send(8'd159);
    for (int i = 0; i < 10; i++) send(8'd130);
    for (int i = 0; i < 4; i++) send(TH_HI);

    // Fall on exact low threshold
    for (int i = 0; i < 4; i++) send(TH_LO);

    // Invalid cycles interleaved with four valid 200s
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
      step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
      send(8'd200);
    end

    // Reset after the third qualifying sample discards the debounce
    do_reset(1);
    for (int i = 0; i < 3; i++) send(8'd200);
    step(1'b1, 1'b1, 8'd200);
    n_rise_seen = 0;
    for (int i = 0; i < 3; i++) send(8'd200);
    check("no_rise_after_rst", 32'(n_rise_seen), 32'd0);
    send(8'd200);
    check("rise_after_rst", 32'(n_rise_seen), 32'd1);

    // Peak windows from a clean reset: 90 then 8
    do_reset(1);
    for (int i = 0; i < 8; i++) send(pk_pat[i]);
`ifdef FILT_LEVEL_PEAK_EN
    check("peak_second_window", 32'(o_peak), 32'd8);
`else
    check("peak_tied_zero", 32'(o_peak), 32'd0);
`endif

    // Random traffic biased toward the thresholds
    for (int i = 0; i < 300; i++) begin
      logic [7:0] d;
      case ($urandom_range(0, 3))
        0: d = 8'($urandom_range(150, 255));
        1: d = 8'($urandom_range(0, 100));
        2: d = 8'($urandom_range(90, 170));
        default: d = 8'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), d);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
